// File: rtl/truth_table_sweep_ctrl_if.sv
// truth_table_sweep_ctrl_if: bundles the sweep handshake, the shared input vector,
// the two function outputs and the sweep results.
// slave  = sweep controller (takes start/y_ref_i/y_dut_i, drives vector and results)
// master = harness side (drives start and the function outputs, observes the rest)
interface truth_table_sweep_ctrl_if #(
    parameter int N_IN = 8
);
    logic            start;
    logic [N_IN-1:0] vec_o;
    logic            y_ref_i;
    logic            y_dut_i;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   fail_cnt;
    logic [N_IN-1:0] first_fail_vec;
    logic            fail_valid;
    logic [N_IN:0]   onset_cnt;
    modport slave (
        input  start, y_ref_i, y_dut_i,
        output vec_o, busy, done, pass, fail_cnt, first_fail_vec, fail_valid, onset_cnt
    );
    modport master (
        output start, y_ref_i, y_dut_i,
        input  vec_o, busy, done, pass, fail_cnt, first_fail_vec, fail_valid, onset_cnt
    );
endinterface

// File: rtl/truth_table_sweep_ctrl.sv
// truth_table_sweep_ctrl: sweeps all 2^N_IN input vectors into a golden and a reduced
// function, counting mismatches, the lowest failing vector and the reduced onset size.
// Ports: clk (rising edge), rst (sync, active-high), sw (slave modport of
// truth_table_sweep_ctrl_if: start in, vec_o out, y_ref_i/y_dut_i in, busy/done/pass
// and fail_cnt/first_fail_vec/fail_valid/onset_cnt out).
module truth_table_sweep_ctrl #(
    parameter int N_IN         = 8,
    parameter int SETTLE       = 0,
    parameter bit STOP_ON_FAIL = 1'b0
) (
    input logic                     clk,
    input logic                     rst,
    truth_table_sweep_ctrl_if.slave sw
);
    typedef enum logic [1:0] {IDLE, HOLD, SAMPLE, FINISH} state_t;
    localparam logic [3:0]      HOLD_LAST = 4'(SETTLE == 0 ? 0 : SETTLE - 1);
    localparam state_t          STEP      = (SETTLE == 0) ? SAMPLE : HOLD;
    localparam logic [N_IN-1:0] VEC_ONE   = 1;
    state_t          r_state, w_state;
    logic [N_IN-1:0] r_vec, w_vec, r_first, w_first;
    logic [N_IN:0]   r_fail, w_fail, r_onset, w_onset;
    logic [3:0]      r_hold, w_hold;
    logic            r_busy, w_busy, r_done, w_done, r_pass, w_pass, r_fv, w_fv;
    logic            w_mis, w_last;
    assign w_mis  = sw.y_ref_i ^ sw.y_dut_i;
    assign w_last = &r_vec;
    always_comb begin
        w_state = r_state;
        w_vec   = r_vec;
        w_first = r_first;
        w_fail  = r_fail;
        w_onset = r_onset;
        w_hold  = r_hold;
        w_busy  = r_busy;
        w_pass  = r_pass;
        w_fv    = r_fv;
        w_done  = 1'b0;
        case (r_state)
            IDLE: if (sw.start) begin
                w_state = STEP;
                w_vec   = '0;
                w_hold  = '0;
                w_fail  = '0;
                w_onset = '0;
                w_first = '0;
                w_fv    = 1'b0;
                w_pass  = 1'b0;
                w_busy  = 1'b1;
            end
            HOLD: begin
                w_hold  = r_hold + 4'd1;
                w_state = (r_hold == HOLD_LAST) ? SAMPLE : HOLD;
            end
            SAMPLE: begin
                w_fail  = r_fail + (N_IN+1)'(w_mis);
                w_onset = r_onset + (N_IN+1)'(sw.y_dut_i);
                w_first = (w_mis && !r_fv) ? r_vec : r_first;
                w_fv    = r_fv | w_mis;
                // the last vector ends the sweep so vec_o never wraps
                if (w_last || (STOP_ON_FAIL && w_mis)) begin
                    w_state = FINISH;
                    w_done  = 1'b1;
                    w_busy  = 1'b0;
                    w_pass  = (w_fail == '0);
                end else begin
                    w_vec   = r_vec + VEC_ONE;
                    w_hold  = '0;
                    w_state = STEP;
                end
            end
            FINISH: w_state = IDLE;
            default: w_state = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_vec   <= '0;
            r_first <= '0;
            r_fail  <= '0;
            r_onset <= '0;
            r_hold  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_fv    <= 1'b0;
        end else begin
            r_state <= w_state;
            r_vec   <= w_vec;
            r_first <= w_first;
            r_fail  <= w_fail;
            r_onset <= w_onset;
            r_hold  <= w_hold;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_pass  <= w_pass;
            r_fv    <= w_fv;
        end
    end
    assign sw.vec_o          = r_vec;
    assign sw.busy           = r_busy;
    assign sw.done           = r_done;
    assign sw.pass           = r_pass;
    assign sw.fail_cnt       = r_fail;
    assign sw.first_fail_vec = r_first;
    assign sw.fail_valid     = r_fv;
    assign sw.onset_cnt      = r_onset;
endmodule

// File: doc/truth_table_sweep_ctrl.md
Name: truth_table_sweep_ctrl

Overview:
Sequencer that exhaustively sweeps the input space of a combinational N_IN-input, 1-output logic function, such as a reduced PLA benchmark netlist. It drives one shared input vector into two instances: the golden (original) function and the reduced/optimized function. Each cycle it compares the two outputs and accumulates mismatch count, first failing vector and onset size. It sits in the equivalence-check harness around each benchmark pair and reports pass/fail with a start/done handshake.

Parameters:
N_IN, 8, number of function inputs; sweep covers 2^N_IN vectors
SETTLE, 0, extra hold cycles per vector before sampling (0..15), for registered or slow paths
STOP_ON_FAIL, 0, 1 = terminate sweep at first mismatch

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request a sweep; sampled only in IDLE
vec_o  out  N_IN  input vector to both functions (bit i drives x_i)
y_ref_i  in  1  golden function output for vec_o
y_dut_i  in  1  reduced function output for vec_o
busy  out  1  high while a sweep is in progress
done  out  1  one-cycle pulse when a sweep ends
pass  out  1  valid after done: 1 iff zero mismatches
fail_cnt  out  N_IN+1  number of mismatching vectors (0..2^N_IN)
first_fail_vec  out  N_IN  lowest mismatching vector
fail_valid  out  1  first_fail_vec holds a valid value
onset_cnt  out  N_IN+1  number of vectors with y_dut_i=1 among those sampled

Behaviour:
- Reset (synchronous, active-high) outputs: vec_o=0, busy=0, done=0, pass=0, fail_cnt=0, first_fail_vec=0, fail_valid=0, onset_cnt=0. State goes to IDLE. Reset overrides start.
- FSM states: IDLE, HOLD, SAMPLE, FINISH.
- IDLE + start=1: clear all counters, fail_valid and pass. Load vec_o=0 and hold counter=0. Set busy=1.
  - Next state is SAMPLE if SETTLE=0, otherwise HOLD.
- HOLD: vec_o stable. Hold counter increments each cycle. When the hold counter reaches SETTLE-1, go to SAMPLE.
- SAMPLE, one cycle, sampling y_ref_i and y_dut_i combinationally at the clock edge:
  - Mismatch (y_ref_i != y_dut_i): fail_cnt+1. If fail_valid=0, set first_fail_vec=vec_o and fail_valid=1.
  - y_dut_i=1: onset_cnt+1.
  - If vec_o = 2^N_IN-1, or (STOP_ON_FAIL=1 and mismatch this cycle): go to FINISH.
  - Otherwise: vec_o+1, hold counter=0, go to HOLD (SETTLE>0) or stay in SAMPLE (SETTLE=0).
- FINISH: one cycle. done=1, busy=0, pass=(fail_cnt==0). Then IDLE.
  - vec_o keeps its last value.
  - Results hold until the next accepted start or reset.
- Timing: the full sweep takes 2^N_IN*(SETTLE+1) cycles from the first SAMPLE/HOLD cycle to the last SAMPLE. Done asserts on the next cycle.
  - N_IN=8, SETTLE=0: start accepted at edge t, done high during cycle t+257.
- vec_o never wraps: the final vector is 2^N_IN-1 and the sweep ends there. Counters are N_IN+1 bits, so all-mismatch (2^N_IN) fits without overflow.
- start while busy or in FINISH: ignored, with no restart.
- start held high continuously: a new sweep starts on the first IDLE cycle after FINISH.
- rst during a sweep: immediate return to reset values. The partial results are discarded and done is not pulsed.
- first_fail_vec is always the lowest failing vector, because the sweep is ascending.

Test Plan:
- Tie y_dut_i=y_ref_i to the golden function, start pulse -> done after 257 cycles, pass=1, fail_cnt=0, fail_valid=0, onset_cnt equals the golden onset size.
- y_dut_i = ~y_ref_i -> fail_cnt=256, first_fail_vec=0x00, fail_valid=1, pass=0.
- Inject a single flip at vec 0xA5 -> fail_cnt=1, first_fail_vec=0xA5; with STOP_ON_FAIL=1, done arrives 0xA5+2 cycles after start and vec_o=0xA5.
- SETTLE=2 -> each vector held exactly 3 cycles (checked by monitor), done at 769 cycles, results identical to the SETTLE=0 run.
- Assert rst at vector 0x40 -> next cycle busy=0, vec_o=0, counters 0, no done pulse. A fresh start then completes normally.
- Pulse start at vector 0x10 and start during FINISH -> no restart; the sweep completes with done once. With start held constant, back-to-back sweeps each report correct results.
